// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read/write port across NUM_CORES LSUs, one transaction at a time.
// Latency: request->mem valid +1 cycle, mem ready->core ready +1 cycle; losing cores hold valid until granted.
module data_mem_arbiter #(
   parameter int NUM_CORES          = 4,
   parameter int DATA_MEM_ADDR_BITS = 8,
   parameter int DATA_MEM_DATA_BITS = 8
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_CORES-1:0]                     core_read_valid,
   input  logic [NUM_CORES*DATA_MEM_ADDR_BITS-1:0]  core_read_address,
   output logic [NUM_CORES-1:0]                     core_read_ready,
   output logic [NUM_CORES*DATA_MEM_DATA_BITS-1:0]  core_read_data,
   input  logic [NUM_CORES-1:0]                     core_write_valid,
   input  logic [NUM_CORES*DATA_MEM_ADDR_BITS-1:0]  core_write_address,
   input  logic [NUM_CORES*DATA_MEM_DATA_BITS-1:0]  core_write_data,
   output logic [NUM_CORES-1:0]                     core_write_ready,
   output logic                                     mem_read_valid,
   output logic [DATA_MEM_ADDR_BITS-1:0]            mem_read_address,
   input  logic                                     mem_read_ready,
   input  logic [DATA_MEM_DATA_BITS-1:0]            mem_read_data,
   output logic                                     mem_write_valid,
   output logic [DATA_MEM_ADDR_BITS-1:0]            mem_write_address,
   output logic [DATA_MEM_DATA_BITS-1:0]            mem_write_data,
   input  logic                                     mem_write_ready,
   output logic                                     busy
);
   localparam int A  = DATA_MEM_ADDR_BITS;
   localparam int D  = DATA_MEM_DATA_BITS;
   localparam int GW = $clog2(NUM_CORES);

   typedef enum logic [2:0] {IDLE, READ_REQ, WRITE_REQ, RELAY, RELEASE} state_t;

   state_t           state, state_nxt;
   logic [GW-1:0]    rr_ptr, grant, win;
   logic             found, win_read, is_read, served_vld;
   logic [A-1:0]     addr;
   logic [D-1:0]     wdata, rdata;
   logic [NUM_CORES-1:0] req;

   assign req        = core_read_valid | core_write_valid;
   assign win_read   = core_read_valid[win];
   assign served_vld = is_read ? core_read_valid[grant] : core_write_valid[grant];

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (found) state_nxt = win_read ? READ_REQ : WRITE_REQ;
         READ_REQ:  if (mem_read_ready) state_nxt = RELAY;
         WRITE_REQ: if (mem_write_ready) state_nxt = RELAY;
         RELAY:     state_nxt = RELEASE;
         RELEASE:   if (!served_vld) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant   <= '0;
         rr_ptr  <= '0;
         is_read <= 1'b0;
         addr    <= '0;
         wdata   <= '0;
         rdata   <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               grant   <= win;
               is_read <= win_read;
               addr    <= win_read ? core_read_address[int'(win)*A +: A]
                                   : core_write_address[int'(win)*A +: A];
               wdata   <= core_write_data[int'(win)*D +: D];
            end
            READ_REQ: if (mem_read_ready) rdata <= mem_read_data;
            // Pointer only advances once the served request is withdrawn.
            RELEASE: if (!served_vld)
               rr_ptr <= (grant == GW'(NUM_CORES-1)) ? '0 : grant + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      core_read_ready   = '0;
      core_write_ready  = '0;
      core_read_data    = '0;
      mem_read_valid    = (state == READ_REQ);
      mem_write_valid   = (state == WRITE_REQ);
      mem_read_address  = (state == READ_REQ)  ? addr  : '0;
      mem_write_address = (state == WRITE_REQ) ? addr  : '0;
      mem_write_data    = (state == WRITE_REQ) ? wdata : '0;
      busy              = (state != IDLE);
      if (state == RELAY) begin
         if (is_read) begin
            core_read_ready[grant]             = 1'b1;
            core_read_data[int'(grant)*D +: D] = rdata;
         end else begin
            core_write_ready[grant] = 1'b1;
         end
      end
   end
endmodule
